// File: rtl/prog_mem_arbiter_if.sv
// Host loader/debug port of the program-memory arbiter: request/ack
// transaction signals plus the halt status the host observes.
interface prog_mem_arbiter_if #(
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned DATA_W = 12
);
   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_release;
   logic              host_ack;
   logic [DATA_W-1:0] host_rdata;
   logic              halted;
   logic [ADDR_W:0]   wr_count;

   // host side drives requests and consumes completions
   modport master (
      output host_req, host_we, host_addr, host_wdata, host_release,
      input  host_ack, host_rdata, halted, wr_count
   );

   // arbiter side
   modport slave (
      input  host_req, host_we, host_addr, host_wdata, host_release,
      output host_ack, host_rdata, halted, wr_count
   );
endinterface

// File: rtl/prog_mem_arbiter.sv
// Shares the single-port program RAM between CPU instruction fetch and a host
// loader: halts the CPU at an instruction boundary, serves host accesses, resumes.
module prog_mem_arbiter #(
   parameter int unsigned ADDR_W      = 9,
   parameter int unsigned DATA_W      = 12,
   parameter int unsigned HALT_SETTLE = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_boundary,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   prog_mem_arbiter_if.slave host,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned SET_W = 4;
   localparam int unsigned WRC_W = ADDR_W + 1;
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(HALT_SETTLE - 1);
   localparam logic [WRC_W-1:0] WR_MAX      = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [2:0] {
      S_RUN     = 3'd0,
      S_DRAIN   = 3'd1,
      S_HALTED  = 3'd2,
      S_H_READ  = 3'd3,
      S_H_WRITE = 3'd4,
      S_RESUME  = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [SET_W-1:0]  settle_q, settle_d;
   logic              armed_q, armed_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [WRC_W-1:0]  wr_count_q, wr_count_d;
   logic              stall_q, stall_d;
   logic              halted_q, halted_d;
   logic              ack_q, ack_d;
   logic              we_q, we_d;

   // state and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_RUN;
         settle_q   <= '0;
         armed_q    <= 1'b1;
         hold_q     <= '0;
         rdata_q    <= '0;
         wdata_q    <= '0;
         wr_count_q <= '0;
         stall_q    <= 1'b0;
         halted_q   <= 1'b0;
         ack_q      <= 1'b0;
         we_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         settle_q   <= settle_d;
         armed_q    <= armed_d;
         hold_q     <= hold_d;
         rdata_q    <= rdata_d;
         wdata_q    <= wdata_d;
         wr_count_q <= wr_count_d;
         stall_q    <= stall_d;
         halted_q   <= halted_d;
         ack_q      <= ack_d;
         we_q       <= we_d;
      end
   end

   // next state, datapath updates and address/fetch steering
   always_comb begin
      state_d    = state_q;
      settle_d   = settle_q;
      armed_d    = armed_q;
      hold_d     = hold_q;
      rdata_d    = rdata_q;
      wdata_d    = wdata_q;
      wr_count_d = wr_count_q;
      mem_addr   = cpu_addr;
      cpu_rdata  = hold_q;

      // a host request is armed once req has been seen low since the last accept
      if (!host.host_req) armed_d = 1'b1;

      case (state_q)
         S_RUN: begin
            cpu_rdata = mem_rdata;
            hold_d    = mem_rdata;
            if (host.host_req && cpu_boundary) begin
               state_d    = S_DRAIN;
               settle_d   = '0;
               wr_count_d = '0;
            end
         end
         S_DRAIN: begin
            if (settle_q == SETTLE_LAST) state_d = S_HALTED;
            else                         settle_d = settle_q + SET_W'(1);
         end
         S_HALTED: begin
            // host address is presented here so read data lands during H_READ
            mem_addr = host.host_addr;
            if (host.host_release) begin
               state_d = S_RESUME;
            end else if (host.host_req && armed_q) begin
               armed_d = 1'b0;
               if (host.host_we) begin
                  state_d = S_H_WRITE;
                  wdata_d = host.host_wdata;
               end else begin
                  state_d = S_H_READ;
               end
            end
         end
         S_H_WRITE: begin
            mem_addr = host.host_addr;
            state_d  = S_HALTED;
            if (wr_count_q != WR_MAX) wr_count_d = wr_count_q + WRC_W'(1);
         end
         S_H_READ: begin
            mem_addr = host.host_addr;
            rdata_d  = mem_rdata;
            state_d  = S_HALTED;
         end
         S_RESUME: begin
            hold_d  = mem_rdata;
            state_d = S_RUN;
         end
         default: begin
            state_d = S_RUN;
         end
      endcase

      stall_d  = (state_d != S_RUN);
      halted_d = (state_d == S_HALTED) || (state_d == S_H_READ) || (state_d == S_H_WRITE);
      ack_d    = (state_q == S_H_READ) || (state_q == S_H_WRITE);
      we_d     = (state_d == S_H_WRITE);
   end

   assign cpu_stall       = stall_q;
   assign mem_we          = we_q;
   assign mem_wdata       = wdata_q;
   assign host.host_ack   = ack_q;
   assign host.host_rdata = rdata_q;
   assign host.halted     = halted_q;
   assign host.wr_count   = wr_count_q;

   // the RAM is written only from H_WRITE and never addressed by the host while the CPU fetches
   a_we_only_hwrite : assert property (@(posedge clk) disable iff (!rst)
      mem_we |-> (state_q == S_H_WRITE));
   a_cpu_addr_run : assert property (@(posedge clk) disable iff (!rst)
      ((state_q == S_RUN) || (state_q == S_RESUME)) |-> (mem_addr == cpu_addr));

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Directed self-checking bench for prog_mem_arbiter with a 1-cycle-latency RAM model.
module tb_prog_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [8:0]  cpu_addr;
   logic        cpu_boundary;
   logic [11:0] cpu_rdata;
   logic        cpu_stall;
   logic [8:0]  mem_addr;
   logic        mem_we;
   logic [11:0] mem_wdata;
   logic [11:0] mem_rdata;

   int tests = 0;
   int fails = 0;

   prog_mem_arbiter_if #(.ADDR_W(9), .DATA_W(12)) hif ();

   prog_mem_arbiter #(.ADDR_W(9), .DATA_W(12), .HALT_SETTLE(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .cpu_addr     (cpu_addr),
      .cpu_boundary (cpu_boundary),
      .cpu_rdata    (cpu_rdata),
      .cpu_stall    (cpu_stall),
      .host         (hif),
      .mem_addr     (mem_addr),
      .mem_we       (mem_we),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   always #5 clk = ~clk;

   // program RAM: word i defaults to 0x300+i, synchronous read
   logic [11:0] ram [512];
   logic        ram_ready = 1'b0;
   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < 512; i++) ram[i] <= 12'(12'h300 + i);
         ram_ready <= 1'b1;
      end else if (mem_we) begin
         ram[mem_addr] <= mem_wdata;
      end
      mem_rdata <= ram[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst               = 1'b0;
      cpu_addr          = 9'h003;
      cpu_boundary      = 1'b1;
      hif.host_req      = 1'b0;
      hif.host_we       = 1'b0;
      hif.host_addr     = '0;
      hif.host_wdata    = '0;
      hif.host_release  = 1'b0;
      tick(); tick();

      // reset state
      chk("rst_stall",  32'(cpu_stall), 32'd0);
      chk("rst_ack",    32'(hif.host_ack), 32'd0);
      chk("rst_rdata",  32'(hif.host_rdata), 32'h000);
      chk("rst_we",     32'(mem_we), 32'd0);
      chk("rst_wrcnt",  32'(hif.wr_count), 32'd0);
      chk("rst_halted", 32'(hif.halted), 32'd0);
      rst = 1'b1;

      // RUN pass-through fetch
      cpu_addr = 9'h005;
      tick(); tick();
      chk("run_addr",  32'(mem_addr), 32'h005);
      chk("run_fetch", 32'(cpu_rdata), 32'h305);
      cpu_addr = 9'h003;
      tick(); tick();
      chk("run_fetch3", 32'(cpu_rdata), 32'h303);

      // halt then write 0xC05 at 0x010
      hif.host_req = 1'b1; hif.host_we = 1'b1;
      hif.host_addr = 9'h010; hif.host_wdata = 12'hC05;
      tick();
      chk("drain_stall",  32'(cpu_stall), 32'd1);
      chk("drain_halted", 32'(hif.halted), 32'd0);
      chk("drain_hold",   32'(cpu_rdata), 32'h303);
      tick();
      chk("drain2_halted", 32'(hif.halted), 32'd0);
      tick();
      chk("halt_halted", 32'(hif.halted), 32'd1);
      chk("halt_we",     32'(mem_we), 32'd0);
      chk("halt_addr",   32'(mem_addr), 32'h010);
      tick();
      chk("wr_we",    32'(mem_we), 32'd1);
      chk("wr_addr",  32'(mem_addr), 32'h010);
      chk("wr_wdata", 32'(mem_wdata), 32'hC05);
      chk("wr_noack", 32'(hif.host_ack), 32'd0);
      tick();
      chk("wr_ack",   32'(hif.host_ack), 32'd1);
      chk("wr_we_off", 32'(mem_we), 32'd0);
      chk("wr_count1", 32'(hif.wr_count), 32'd1);
      hif.host_req = 1'b0;
      tick();
      chk("wr_ack_pulse", 32'(hif.host_ack), 32'd0);

      // read back 0x010, then hold req high: no second transaction
      hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_addr = 9'h010;
      tick();
      chk("rd_noack", 32'(hif.host_ack), 32'd0);
      chk("rd_halted", 32'(hif.halted), 32'd1);
      tick();
      chk("rd_ack",   32'(hif.host_ack), 32'd1);
      chk("rd_data",  32'(hif.host_rdata), 32'hC05);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rd_held_noack", 32'(hif.host_ack), 32'd0);
         chk("rd_held_data",  32'(hif.host_rdata), 32'hC05);
      end
      hif.host_req = 1'b0;
      tick();
      hif.host_req = 1'b1; hif.host_addr = 9'h003;
      tick(); tick();
      chk("rd2_ack",  32'(hif.host_ack), 32'd1);
      chk("rd2_data", 32'(hif.host_rdata), 32'h303);
      hif.host_req = 1'b0;
      tick();

      // overwrite the word at PC=0x003, then resume
      hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_wdata = 12'hA05;
      tick(); tick();
      chk("mod_ack",    32'(hif.host_ack), 32'd1);
      chk("mod_wrcnt",  32'(hif.wr_count), 32'd2);
      hif.host_req = 1'b0;
      tick();
      hif.host_release = 1'b1;
      tick();
      hif.host_release = 1'b0;
      chk("resume_stall",  32'(cpu_stall), 32'd1);
      chk("resume_halted", 32'(hif.halted), 32'd0);
      chk("resume_addr",   32'(mem_addr), 32'h003);
      tick();
      chk("run1_stall", 32'(cpu_stall), 32'd0);
      chk("run1_fetch", 32'(cpu_rdata), 32'hA05);

      // request while not at a boundary: the host waits
      cpu_boundary = 1'b0;
      hif.host_req = 1'b1; hif.host_we = 1'b1;
      hif.host_addr = 9'h020; hif.host_wdata = 12'h111;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bw_stall", 32'(cpu_stall), 32'd0);
         chk("bw_fetch", 32'(cpu_rdata), 32'hA05);
      end
      cpu_boundary = 1'b1;
      tick();
      chk("bw_drain_stall", 32'(cpu_stall), 32'd1);
      chk("bw_wrcnt_clr",   32'(hif.wr_count), 32'd0);
      tick(); tick();
      chk("bw_halted", 32'(hif.halted), 32'd1);

      // release collides with a pending request: release wins
      hif.host_release = 1'b1;
      tick();
      hif.host_release = 1'b0;
      hif.host_req = 1'b0;
      chk("col_we",     32'(mem_we), 32'd0);
      chk("col_ack",    32'(hif.host_ack), 32'd0);
      chk("col_halted", 32'(hif.halted), 32'd0);
      chk("col_stall",  32'(cpu_stall), 32'd1);
      tick();
      chk("col_run_stall", 32'(cpu_stall), 32'd0);
      chk("col_run_ack",   32'(hif.host_ack), 32'd0);
      chk("col_wrcnt",     32'(hif.wr_count), 32'd0);

      // async reset in the middle of a host write
      hif.host_req = 1'b1; hif.host_we = 1'b1;
      hif.host_addr = 9'h030; hif.host_wdata = 12'h777;
      tick(); tick(); tick(); tick();
      chk("ar_we_before", 32'(mem_we), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("ar_we_now",     32'(mem_we), 32'd0);
      chk("ar_stall_now",  32'(cpu_stall), 32'd0);
      chk("ar_halted_now", 32'(hif.halted), 32'd0);
      hif.host_req = 1'b0;
      tick();
      rst = 1'b1;
      tick(); tick();
      chk("ar_wrcnt",  32'(hif.wr_count), 32'd0);
      chk("ar_stall",  32'(cpu_stall), 32'd0);
      chk("ar_addr",   32'(mem_addr), 32'h003);
      chk("ar_fetch",  32'(cpu_rdata), 32'hA05);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/prog_mem_arbiter.md
Name: prog_mem_arbiter

Overview:
- Shares the single-port program memory between the CPU instruction-fetch path and a host loader/debug port.
- Sits between the PC/instruction register datapath and the program RAM.
- Halts the CPU cleanly at an instruction boundary, using the cpu_boundary flag that the CPU controller asserts when no call/goto/retlw extra cycle is pending.
- Serves host reads/writes with a req/ack handshake, then re-primes the fetch and resumes the CPU.

Parameters:
ADDR_W, 9, program memory address width (512 words).
DATA_W, 12, instruction width.
HALT_SETTLE, 2, cycles held in DRAIN after stall asserts before host access is allowed (1..15).

Ports:
clk  input  1  system clock; all state on posedge.
rst  input  1  asynchronous, active-low reset.
cpu_addr  input  ADDR_W  current PC from the CPU datapath.
cpu_boundary  input  1  high when the CPU controller is at an instruction boundary (no multi-cycle op in flight).
cpu_rdata  output  DATA_W  instruction word to the instruction register.
cpu_stall  output  1  freezes the CPU controller (no IR load, no PC increment) while high.
host_req  input  1  host transaction request; level, held until host_ack.
host_we  input  1  1 = write, 0 = read; sampled with host_req.
host_addr  input  ADDR_W  host address.
host_wdata  input  DATA_W  host write data.
host_release  input  1  single-cycle pulse: leave halt and resume the CPU.
host_ack  output  1  single-cycle completion pulse.
host_rdata  output  DATA_W  read data; valid in the host_ack cycle and held after.
halted  output  1  high in HALTED, H_READ and H_WRITE.
wr_count  output  ADDR_W+1  number of host writes since the last halt entry.
mem_addr  output  ADDR_W  program RAM address.
mem_we  output  1  program RAM write enable.
mem_wdata  output  DATA_W  program RAM write data.
mem_rdata  input  DATA_W  program RAM read data; synchronous, 1-cycle latency.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN; cpu_stall=0, host_ack=0, host_rdata=0, mem_we=0, wr_count=0, halted=0.
  - Hold register = 0; settle counter = 0.
  - mem_we must drop immediately, even mid-write.
- States: RUN, DRAIN, HALTED, H_READ, H_WRITE, RESUME.
- RUN:
  - mem_addr=cpu_addr; cpu_rdata=mem_rdata (pass-through); hold register captures mem_rdata every cycle.
  - host_req=1 and cpu_boundary=1 → DRAIN. cpu_stall registers high the next cycle; wr_count clears.
  - host_req=1 and cpu_boundary=0 → remain in RUN until a boundary occurs. The host simply waits.
- DRAIN:
  - cpu_stall=1; cpu_rdata=hold register; mem_addr=cpu_addr.
  - Counts HALT_SETTLE cycles, then → HALTED.
  - host_req dropping during DRAIN does not abort; the arbiter still ends in HALTED.
  - host_release during DRAIN is ignored.
- HALTED:
  - cpu_stall=1, halted=1; mem_addr=host_addr.
  - A new request is accepted only after host_req has been observed low at least one cycle since the previous ack (edge-armed).
  - Accepted request with host_we=1 → H_WRITE; with host_we=0 → H_READ.
  - host_release=1 → RESUME, taking priority over a simultaneous host_req.
- H_WRITE (1 cycle):
  - mem_we=1, mem_addr=host_addr, mem_wdata=host_wdata.
  - Next cycle: host_ack=1, wr_count+1 (saturates at 2^ADDR_W), → HALTED.
- H_READ (1 cycle):
  - mem_addr=host_addr.
  - Next cycle: host_rdata<=mem_rdata, host_ack=1, → HALTED.
- RESUME (1 cycle):
  - mem_addr=cpu_addr, cpu_stall=1; hold register captures mem_rdata at cycle end.
  - Next cycle → RUN with cpu_stall=0. The first instruction the CPU sees is the word at the unchanged PC, including any word just overwritten.
- Address invariant: mem_addr is never driven from host_addr in RUN or RESUME.
- Write-enable invariant: mem_we is high only in H_WRITE.
- Latency: halt = 1 + HALTED_SETTLE... precisely 1 + HALT_SETTLE cycles from the accepting boundary to halted=1. Write and read each ack 2 cycles after acceptance. Resume takes 2 cycles from the host_release pulse to cpu_stall=0.

Test Plan:
- Halt then write: in RUN with cpu_boundary=1, assert host_req, host_we=1, addr=0x010, wdata=0xC05. Required: cpu_stall rises next cycle; halted after 3 cycles; mem_we pulses once with addr 0x010; host_ack one cycle; wr_count=1.
- Read-back: while halted, read 0x010 → host_rdata=0xC05 in the ack cycle. Holding host_req high after ack causes no second transaction until req goes low and high again.
- Boundary wait: host_req held while cpu_boundary=0 for 5 cycles (simulating a goto extra cycle). Required: cpu_stall stays 0 and the CPU fetch is uninterrupted; halt begins on the first cycle with cpu_boundary=1.
- Resume with modified code: write 0xA05 at the current PC=0x003, then pulse host_release. Required: RESUME for 1 cycle; cpu_stall=0 one cycle later; cpu_rdata=0xA05 on the first RUN cycle.
- Release vs. request collision: host_release and host_req high in the same HALTED cycle. Required: → RESUME, no mem_we, no host_ack.
- Async reset mid-write: drive rst=0 during H_WRITE. Required: mem_we=0 and cpu_stall=0 immediately, without waiting for clk; state=RUN and wr_count=0 after rst returns high.
